// File: rtl/adder_operand_gather.sv
// adder_operand_gather
// Packs four consecutive W-bit operands plus a carry-in into the 4*W+1-bit
// input group of the 4-operand adder, and holds the group until accepted.
// ins layout: [W-1:0]=x, [2W-1:W]=y, [3W-1:2W]=z, [4W-1:3W]=w, [4W]=cin.
//
// Optional build macro GATHER_TIMEOUT_EN: a partial group that sees TIMEOUT
// idle cycles is closed early with its unwritten slots and cin at 0.
//
// state   | meaning
// COLLECT | accepting operand beats into slots x, y, z, w in order
// FULL    | group complete; ins held stable until out_ready

module adder_operand_gather #(
    parameter int W       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic           in_cin,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [4*W:0]   ins,
    output logic [2:0]     fill
);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t       state, state_nxt;
    logic [4*W:0] ins_nxt;
    logic [2:0]   fill_nxt;
    logic         accept;
    logic         timeout_fire;

    // in_ready also drops on the cycle a timeout closes the group, so a
    // beat arriving then cannot land in a group that is being committed.
    assign in_ready  = (state == COLLECT) && !flush && !rst && !timeout_fire;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == FULL);

`ifdef GATHER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] idle_cnt;

    // Count idle cycles while a partial group is waiting; saturates at TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst || (state != COLLECT) || flush || accept || (fill == 3'd0)) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TW'(TIMEOUT)) begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

    assign timeout_fire = (state == COLLECT) && (fill != 3'd0) &&
                          (idle_cnt == TW'(TIMEOUT));
`else
    // Without the timeout a partial group simply waits for more beats.
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT > 0);
    assign timeout_fire   = 1'b0;
`endif

    // State, group bus and slot count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
            ins   <= '0;
            fill  <= 3'd0;
        end else begin
            state <= state_nxt;
            ins   <= ins_nxt;
            fill  <= fill_nxt;
        end
    end

    // Next-state: slot writes, group completion, flush and handoff.
    always_comb begin
        state_nxt = state;
        ins_nxt   = ins;
        fill_nxt  = fill;
        case (state)
            COLLECT: begin
                if (flush) begin
                    ins_nxt  = '0;
                    fill_nxt = 3'd0;
                end else if (timeout_fire) begin
                    // Remaining slots and cin are already 0 from the last clear.
                    state_nxt = FULL;
                    fill_nxt  = 3'd4;
                end else if (accept) begin
                    case (fill[1:0])
                        2'd0:    ins_nxt[W-1:0]     = in_data;
                        2'd1:    ins_nxt[2*W-1:W]   = in_data;
                        2'd2:    ins_nxt[3*W-1:2*W] = in_data;
                        default: begin
                            ins_nxt[4*W-1:3*W] = in_data;
                            ins_nxt[4*W]       = in_cin;
                            state_nxt          = FULL;
                        end
                    endcase
                    fill_nxt = fill + 3'd1;
                end
            end
            FULL: begin
                // flush is deliberately ignored here: the group is committed.
                if (out_ready) begin
                    state_nxt = COLLECT;
                    ins_nxt   = '0;
                    fill_nxt  = 3'd0;
                end
            end
            default: begin
                state_nxt = COLLECT;
                ins_nxt   = '0;
                fill_nxt  = 3'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_adder_operand_gather.sv
// Testbench for adder_operand_gather: directed scenarios plus random traffic,
// every cycle compared against a group-level reference model.
module tb_adder_operand_gather;

    localparam int W       = 8;
    localparam int TIMEOUT = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           in_cin;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [4*W:0]   ins;
    logic [2:0]     fill;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: list of operands collected so far, cin, done flag, idle count.
    logic [W-1:0] m_ops[$];
    bit           m_cin;
    bit           m_full;
    int           m_idle;

    adder_operand_gather #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cin    (in_cin),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ins       (ins),
        .fill      (fill)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [63:0] model_ins();
        logic [63:0] v = 64'd0;
        for (int i = 0; i < m_ops.size(); i++)
            v = v + (64'(m_ops[i]) << (W * i));
        v = v + (64'(m_cin) << (4 * W));
        return v;
    endfunction

    task automatic model_clear();
        m_ops.delete();
        m_cin  = 1'b0;
        m_full = 1'b0;
        m_idle = 0;
    endtask

    // One clock cycle: drive at negedge, compare, advance the model, wait for posedge.
    task automatic cycle(input bit r, input bit v, input logic [W-1:0] d,
                         input bit c, input bit f, input bit o);
        bit fire, exp_rdy, acc;
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; in_cin = c; flush = f; out_ready = o;
        #1;
`ifdef GATHER_TIMEOUT_EN
        fire = !m_full && (m_ops.size() > 0) && (m_idle >= TIMEOUT);
`else
        fire = 1'b0;
`endif
        exp_rdy = !m_full && !f && !r && !fire;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("out_valid", 64'(out_valid), 64'(m_full));
        check("ins", 64'(ins), model_ins());
        check("fill", 64'(fill), m_full ? 64'd4 : 64'(m_ops.size()));
        acc = v && exp_rdy;
        if (r) model_clear();
        else if (m_full) begin
            if (o) model_clear();
        end else if (f) model_clear();
        else if (fire) begin
            while (m_ops.size() < 4) m_ops.push_back('0);
            m_full = 1'b1;
            m_idle = 0;
        end else if (acc) begin
            m_ops.push_back(d);
            m_idle = 0;
            if (m_ops.size() == 4) begin
                m_cin  = c;
                m_full = 1'b1;
            end
        end else if (m_ops.size() > 0) m_idle++;
        @(posedge clk);
    endtask

    task automatic idle(input bit o);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, o);
    endtask

    int first_ov;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_cin = 1'b0; flush = 1'b0; out_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        cycle(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        #1;
        check("rst_ins", 64'(ins), 64'd0);
        check("rst_fill", 64'(fill), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);

        // Basic group with downstream always ready.
        cycle(0, 1, 8'h01, 0, 0, 1); #1; check("tp1_fill1", 64'(fill), 64'd1);
        cycle(0, 1, 8'h02, 0, 0, 1); #1; check("tp1_fill2", 64'(fill), 64'd2);
        cycle(0, 1, 8'h03, 0, 0, 1); #1; check("tp1_fill3", 64'(fill), 64'd3);
        check("tp1_ov_early", 64'(out_valid), 64'd0);
        cycle(0, 1, 8'h04, 1, 0, 1); #1;
        check("tp1_ov", 64'(out_valid), 64'd1);
        check("tp1_ins", 64'(ins), 64'h1_04030201);
        check("tp1_fill4", 64'(fill), 64'd4);
        idle(1); #1;
        check("tp1_fill0", 64'(fill), 64'd0);
        check("tp1_ins_clr", 64'(ins), 64'd0);

        // Backpressure: group held while in_valid keeps offering 0xAA.
        cycle(0, 1, 8'h10, 0, 0, 0);
        cycle(0, 1, 8'h20, 0, 0, 0);
        cycle(0, 1, 8'h30, 0, 0, 0);
        cycle(0, 1, 8'h40, 1, 0, 0);
        repeat (5) cycle(0, 1, 8'hAA, 0, 0, 0);
        #1; check("tp2_ins_hold", 64'(ins), 64'h1_40302010);
        cycle(0, 1, 8'hAA, 0, 0, 1); #1;
        check("tp2_handoff_fill", 64'(fill), 64'd0);
        cycle(0, 1, 8'hAA, 0, 0, 0); #1;
        check("tp2_aa_slot_x", 64'(ins), 64'h0_000000AA);
        check("tp2_aa_fill", 64'(fill), 64'd1);
        cycle(0, 0, '0, 0, 1, 0);

        // Flush with a simultaneous beat, then a fresh group.
        cycle(0, 1, 8'h11, 0, 0, 0);
        cycle(0, 1, 8'h22, 0, 0, 0);
        cycle(0, 1, 8'h33, 0, 1, 0); #1;
        check("tp3_flush_fill", 64'(fill), 64'd0);
        check("tp3_flush_ins", 64'(ins), 64'd0);
        cycle(0, 1, 8'h44, 1, 0, 0);
        cycle(0, 1, 8'h55, 1, 0, 0);
        cycle(0, 1, 8'h66, 1, 0, 0);
        cycle(0, 1, 8'h77, 0, 0, 0); #1;
        check("tp3_ins", 64'(ins), 64'h0_77665544);
        cycle(0, 0, '0, 0, 1, 0); #1;
        check("tp3_flush_in_full", 64'(out_valid), 64'd1);
        idle(1);

        // All-ones group, then reset while FULL.
        repeat (4) cycle(0, 1, 8'hFF, 1, 0, 0);
        #1; check("tp4_ins", 64'(ins), 64'h1_FFFFFFFF);
        cycle(1, 0, '0, 0, 0, 0); #1;
        check("tp4_rst_ov", 64'(out_valid), 64'd0);
        check("tp4_rst_ins", 64'(ins), 64'd0);
        check("tp4_rst_fill", 64'(fill), 64'd0);

        // Stalled partial group.
        cycle(0, 1, 8'h05, 0, 0, 0);
        cycle(0, 1, 8'h06, 0, 0, 0);
        first_ov = 0;
        for (int k = 1; k <= 100; k++) begin
            idle(0);
            #1;
            if (out_valid && first_ov == 0) first_ov = k;
        end
`ifdef GATHER_TIMEOUT_EN
        check("tp5_timeout_lat", 64'(first_ov), 64'd17);
        check("tp5_timeout_ins", 64'(ins), 64'h0_00000605);
        check("tp5_timeout_fill", 64'(fill), 64'd4);
`else
        check("tp5_no_timeout", 64'(first_ov), 64'd0);
        check("tp5_partial_fill", 64'(fill), 64'd2);
        check("tp5_partial_ins", 64'(ins), 64'h0_00000605);
`endif
        cycle(1, 0, '0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 63) == 0,
                  $urandom_range(0, 3) != 0,
                  W'($urandom),
                  1'($urandom),
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_operand_gather.md
Name: adder_operand_gather

Overview:
Upstream feeder for the 4-operand adder stage. Accepts a serial stream of W-bit operands on a valid/ready handshake. Packs four consecutive operands plus a carry-in into the adder's 4*W+1-bit `ins` bus, then holds that group until the downstream stage accepts it. Decouples narrow operand producers from the wide, single-cycle adder input.

Parameters:
W, 8, operand width; output bus is 4*W+1 bits.
TIMEOUT, 16, idle-cycle limit for a partial group; used only when GATHER_TIMEOUT_EN is defined; must be >= 1.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  reset; synchronous, active-high.
in_valid  input  1  operand beat valid.
in_ready  output  1  block can accept a beat this cycle.
in_data  input  W  operand value.
in_cin  input  1  carry-in; sampled only on the beat that fills slot 3.
flush  input  1  discard the partial group being collected.
out_valid  output  1  `ins` holds a complete group.
out_ready  input  1  downstream accepts the group.
ins  output  4*W+1  packed group: [W-1:0]=x, [2W-1:W]=y, [3W-1:2W]=z, [4W-1:3W]=w, [4W]=cin.
fill  output  3  number of slots written in the current group, 0..4.

Behaviour:
- Reset (rst=1 at a clock edge): state=COLLECT, ins=0, fill=0, out_valid=0, timeout counter=0. in_ready=0 while rst is high.
- States: COLLECT and FULL.
  - in_ready = (state==COLLECT) && !flush && !rst.
  - out_valid = (state==FULL), registered.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
  - It writes in_data into slot `fill` (0=x, 1=y, 2=z, 3=w), then fill increments.
  - Slots are written in order; no out-of-order writes.
- Group completion: on the beat that writes slot 3, in_cin is written to ins[4W], fill becomes 4 and state becomes FULL. out_valid goes high on the next cycle (1-cycle latency from the 4th accept).
- FULL state:
  - ins is held stable, out_valid stays 1 and in_ready stays 0 until out_ready=1.
  - On the out_valid && out_ready edge: state=COLLECT, fill=0, ins cleared to 0. in_ready is high the following cycle.
  - Peak throughput: one group per 5 cycles.
- Flush:
  - In COLLECT, flush=1 clears fill and ins to 0. A simultaneous in_valid beat is not accepted, because in_ready is low.
  - In FULL, flush is ignored; the group is already committed.
- Unwritten slots of a group in progress read 0, because ins is cleared at handoff, flush and reset.
- Reset mid-group or mid-FULL discards all data with no output handshake.
- in_data is taken as-is; no arithmetic is performed here. The downstream adder sums the fields.

Optional Feature:
GATHER_TIMEOUT_EN
- Defined:
  - A counter runs in COLLECT while 0 < fill < 4 and no beat is accepted. Any accepted beat, flush or reset clears it.
  - When the counter reaches TIMEOUT, the block moves to FULL with the remaining slots and cin at 0, and fill is forced to 4.
  - out_valid rises on the next cycle.
  - A beat arriving in the same cycle the timeout fires is not accepted; in_ready is already low that cycle.
- Not defined: no counter is instantiated. A partial group waits indefinitely. The TIMEOUT parameter is unused.

Test Plan:
- W=8. Beats 0x01, 0x02, 0x03, 0x04, cin=1 on the 4th beat, out_ready=1 → out_valid high exactly 1 cycle after the 4th accept; ins=33'h1_04030201; fill sequence 1,2,3,4,0.
- Full group with out_ready=0 for 5 cycles, in_valid held high with 0xAA → in_ready=0 throughout; ins stays stable; 0xAA is accepted as slot x only after the handoff cycle.
- Beats 0x11, 0x22, then flush=1 together with in_valid=1 carrying 0x33 → fill=0, ins=0, 0x33 not accepted. Next beats 0x44, 0x55, 0x66, 0x77, cin=0 → ins=33'h0_77665544.
- Beats 0xFF ×4, cin=1 → ins=33'h1_FFFFFFFF. Then assert rst for 1 cycle while in FULL → out_valid=0, ins=0, fill=0 on the next cycle.
- GATHER_TIMEOUT_EN defined, TIMEOUT=16: beats 0x05, 0x06, then idle → out_valid rises 17 cycles after the 2nd accept; ins=33'h0_00000605. With the macro undefined, the same stimulus keeps out_valid=0 for 100 cycles.
